// File: rtl/cic_seq_pkg.sv
// Shared constants for the CIC sequencer: FSM state encodings, default channel/stage
// counts and the stage-index width helper.
package cic_pkg;

    localparam int CIC_CHANNELS = 8;
    localparam int CIC_STAGES   = 3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INTEG    = 3'd1;
    localparam logic [2:0] S_COMB     = 3'd2;
    localparam logic [2:0] S_WAIT_OUT = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    // A single-stage filter still needs a 1-bit stage field in the address.
    function automatic int stage_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cic_seq_if.sv
// Control/status bundle between the PDM timing logic, the CIC arithmetic and the
// PCM sink; the sequencer sits on the slave side.
interface cic_seq_if #(
    parameter int CHANNELS = cic_pkg::CIC_CHANNELS,
    parameter int STAGES   = cic_pkg::CIC_STAGES
);
    localparam int CHANNELS_WIDTH = $clog2(CHANNELS);
    localparam int STAGE_WIDTH    = cic_pkg::stage_width(STAGES);
    localparam int ADDR_WIDTH     = CHANNELS_WIDTH + STAGE_WIDTH;

    logic                      read_enable;
    logic                      comb_enable;
    logic                      pcm_ready;
    logic                      clear_overrun;
    logic [CHANNELS_WIDTH-1:0] channel;
    logic [STAGE_WIDTH-1:0]    stage;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic                      integ_we;
    logic                      comb_we;
    logic                      pcm_valid;
    logic [CHANNELS_WIDTH-1:0] pcm_channel;
    logic                      cic_finish;
    logic                      busy;
    logic                      overrun;

    modport slave (
        input  read_enable, comb_enable, pcm_ready, clear_overrun,
        output channel, stage, mem_addr, integ_we, comb_we, pcm_valid,
               pcm_channel, cic_finish, busy, overrun
    );

    modport master (
        output read_enable, comb_enable, pcm_ready, clear_overrun,
        input  channel, stage, mem_addr, integ_we, comb_we, pcm_valid,
               pcm_channel, cic_finish, busy, overrun
    );
endinterface

// File: rtl/cic_seq_counter.sv
// Nested channel/stage index counter: full nested advance, stage-only wrap,
// channel-only advance, and last-index flags for the sequencer FSM.
module cic_seq_counter #(
    parameter int CHANNELS = 8,
    parameter int STAGES   = 3,
    parameter int CW       = 3,
    parameter int SW       = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          adv_i,
    input  logic          stage_adv_i,
    input  logic          chan_adv_i,
    output logic [CW-1:0] channel_o,
    output logic [SW-1:0] stage_o,
    output logic          last_channel_o,
    output logic          last_stage_o
);
    logic [CW-1:0] channel_q, channel_d;
    logic [SW-1:0] stage_q, stage_d;

    assign last_channel_o = (channel_q == CW'(CHANNELS - 1));
    assign last_stage_o   = (stage_q == SW'(STAGES - 1));
    assign channel_o      = channel_q;
    assign stage_o        = stage_q;

    always_comb begin
        channel_d = channel_q;
        stage_d   = stage_q;
        if (clear_i) begin
            channel_d = '0;
            stage_d   = '0;
        end else if (adv_i) begin
            if (last_stage_o) begin
                stage_d   = '0;
                channel_d = last_channel_o ? '0 : channel_q + CW'(1);
            end else begin
                stage_d = stage_q + SW'(1);
            end
        end else if (stage_adv_i) begin
            stage_d = last_stage_o ? '0 : stage_q + SW'(1);
        end else if (chan_adv_i) begin
            channel_d = last_channel_o ? '0 : channel_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            channel_q <= '0;
            stage_q   <= '0;
        end else begin
            channel_q <= channel_d;
            stage_q   <= stage_d;
        end
    end
endmodule

// File: rtl/cic_seq.sv
// Time-multiplexed CIC sequencer: integrator sweep, optional comb sweep with PCM
// handshake per channel. Optional sticky overrun detection under CIC_SEQ_OVERRUN_EN.
module cic_seq
    import cic_pkg::*;
#(
    parameter int CHANNELS = CIC_CHANNELS,
    parameter int STAGES   = CIC_STAGES
) (
    input logic      clk,
    input logic      resetn,
    cic_seq_if.slave bus
);
    localparam int CW = $clog2(CHANNELS);
    localparam int SW = stage_width(STAGES);

    logic [2:0]    state_q, state_d;
    logic          comb_pending_q, comb_pending_d;
    logic          cnt_clear, cnt_adv, cnt_stage_adv, cnt_chan_adv;
    logic [CW-1:0] cnt_channel;
    logic [SW-1:0] cnt_stage;
    logic          last_channel, last_stage;
    logic          overrun_w;

    cic_seq_counter #(
        .CHANNELS (CHANNELS),
        .STAGES   (STAGES),
        .CW       (CW),
        .SW       (SW)
    ) u_counter (
        .clk            (clk),
        .rst            (resetn),
        .clear_i        (cnt_clear),
        .adv_i          (cnt_adv),
        .stage_adv_i    (cnt_stage_adv),
        .chan_adv_i     (cnt_chan_adv),
        .channel_o      (cnt_channel),
        .stage_o        (cnt_stage),
        .last_channel_o (last_channel),
        .last_stage_o   (last_stage)
    );

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q        <= S_IDLE;
            comb_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            comb_pending_q <= comb_pending_d;
        end
    end

    // Next state plus counter control; a comb_enable arriving on the last
    // integrator cycle still counts for this pass.
    always_comb begin
        state_d       = state_q;
        cnt_clear     = 1'b0;
        cnt_adv       = 1'b0;
        cnt_stage_adv = 1'b0;
        cnt_chan_adv  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_clear = 1'b1;
                if (bus.read_enable) state_d = S_INTEG;
            end
            S_INTEG: begin
                if (last_channel && last_stage) begin
                    cnt_clear = 1'b1;
                    state_d   = (comb_pending_q || bus.comb_enable) ? S_COMB : S_DONE;
                end else begin
                    cnt_adv = 1'b1;
                end
            end
            S_COMB: begin
                cnt_stage_adv = 1'b1;
                if (last_stage) state_d = S_WAIT_OUT;
            end
            S_WAIT_OUT: begin
                if (bus.pcm_ready) begin
                    if (last_channel) begin
                        cnt_clear = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        cnt_chan_adv = 1'b1;
                        state_d      = S_COMB;
                    end
                end
            end
            S_DONE: begin
                cnt_clear = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        comb_pending_d = comb_pending_q;
        if (state_q == S_DONE)
            comb_pending_d = 1'b0;
        else if (bus.comb_enable && (state_q == S_IDLE || state_q == S_INTEG))
            comb_pending_d = 1'b1;
    end

`ifdef CIC_SEQ_OVERRUN_EN
    logic overrun_q, overrun_d, overrun_event;

    always_comb begin
        overrun_event = (bus.read_enable && state_q != S_IDLE) ||
                        (bus.comb_enable && (state_q == S_COMB ||
                                             state_q == S_WAIT_OUT ||
                                             state_q == S_DONE));
        overrun_d = overrun_q;
        if (bus.clear_overrun) overrun_d = 1'b0;
        if (overrun_event)     overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end

    assign overrun_w = overrun_q;
`else
    logic unused_clear_overrun;
    assign unused_clear_overrun = bus.clear_overrun;
    assign overrun_w = 1'b0;
`endif

    always_comb begin
        bus.channel     = cnt_channel;
        bus.stage       = cnt_stage;
        bus.mem_addr    = {cnt_channel, cnt_stage};
        bus.integ_we    = (state_q == S_INTEG);
        bus.comb_we     = (state_q == S_COMB);
        bus.pcm_valid   = (state_q == S_WAIT_OUT);
        bus.pcm_channel = (state_q == S_WAIT_OUT) ? cnt_channel : '0;
        bus.cic_finish  = (state_q == S_DONE);
        bus.busy        = (state_q != S_IDLE);
        bus.overrun     = overrun_w;
    end
endmodule

// File: tb/tb_cic_seq.sv
// Self-checking bench for cic_seq: table of pass scenarios with expected address and
// PCM-tag queues, plus hand sequences for overrun clear and asynchronous reset.
module tb_cic_seq;
`ifdef CIC_SEQ_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif
    localparam int C = 8;
    localparam int S = 3;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   total = 0;
    int   bad = 0;

    cic_seq_if #(.CHANNELS(C), .STAGES(S)) bus ();

    cic_seq #(.CHANNELS(C), .STAGES(S)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit comb;
        int stall_ch;
        int stall_len;
        int mid_re;
        int mid_ce;
        int mid_clr;
        int exp_finish;
        bit exp_ovr;
        bit clr_after;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"},     int'(bus.busy), 0);
        check({name, "_integ_we"}, int'(bus.integ_we), 0);
        check({name, "_comb_we"},  int'(bus.comb_we), 0);
        check({name, "_pcm_valid"}, int'(bus.pcm_valid), 0);
        check({name, "_pcm_chan"}, int'(bus.pcm_channel), 0);
        check({name, "_finish"},   int'(bus.cic_finish), 0);
        check({name, "_channel"},  int'(bus.channel), 0);
        check({name, "_stage"},    int'(bus.stage), 0);
        check({name, "_addr"},     int'(bus.mem_addr), 0);
        check({name, "_overrun"},  int'(bus.overrun), 0);
    endtask

    task automatic clear_ovr();
        @(negedge clk);
        bus.clear_overrun = 1'b1;
        @(negedge clk);
        bus.clear_overrun = 1'b0;
        check("ovr_clear", int'(bus.overrun), 0);
    endtask

    // read_enable lands in cycle 0; the loop samples and drives once per cycle t >= 1.
    task automatic run_pass(input int idx, input vec_t v);
        int  exp_addr[$];
        int  exp_pcm[$];
        int  stalled = 0;
        int  n_pcm = 0;
        bit  prev_stall = 1'b0;
        bit  done = 1'b0;
        int  e;
        for (int c = 0; c < C; c++)
            for (int s = 0; s < S; s++)
                exp_addr.push_back(c * 4 + s);
        if (v.comb)
            for (int c = 0; c < C; c++) exp_pcm.push_back(c);

        @(negedge clk);
        bus.read_enable   = 1'b1;
        bus.comb_enable   = v.comb;
        bus.pcm_ready     = 1'b1;
        bus.clear_overrun = 1'b0;
        for (int t = 1; t <= 300 && !done; t++) begin
            @(negedge clk);
            bus.read_enable   = (t == v.mid_re);
            bus.comb_enable   = (t == v.mid_ce);
            bus.clear_overrun = (t == v.mid_clr);
            if (prev_stall) begin
                check("stall_valid", int'(bus.pcm_valid), 1);
                check("stall_chan", int'(bus.pcm_channel), v.stall_ch);
            end
            if (bus.pcm_valid && int'(bus.pcm_channel) == v.stall_ch && stalled < v.stall_len) begin
                bus.pcm_ready = 1'b0;
                stalled++;
                prev_stall = 1'b1;
            end else begin
                bus.pcm_ready = 1'b1;
                prev_stall = 1'b0;
            end
            if (bus.integ_we) begin
                if (exp_addr.size() == 0) check("integ_extra", 1, 0);
                else begin
                    e = exp_addr.pop_front();
                    check("integ_addr", int'(bus.mem_addr), e);
                    check("integ_chan", int'(bus.channel), e / 4);
                end
            end
            if (bus.comb_we) begin
                if (exp_pcm.size() == 0) check("comb_extra", 1, 0);
                else check("comb_chan", int'(bus.channel), exp_pcm[0]);
            end
            if (bus.pcm_valid && bus.pcm_ready) begin
                if (exp_pcm.size() == 0) check("pcm_extra", 1, 0);
                else begin
                    e = exp_pcm.pop_front();
                    check("pcm_chan", int'(bus.pcm_channel), e);
                    n_pcm++;
                end
            end
            if (bus.cic_finish) begin
                check("finish_cycle", t, v.exp_finish);
                check("finish_overrun", int'(bus.overrun), int'(v.exp_ovr));
                check("finish_chan", int'(bus.channel), 0);
                done = 1'b1;
            end
        end
        bus.read_enable   = 1'b0;
        bus.comb_enable   = 1'b0;
        bus.clear_overrun = 1'b0;
        bus.pcm_ready     = 1'b1;
        if (!done) check("finish_timeout", 0, 1);
        check("integ_left", exp_addr.size(), 0);
        check("pcm_left", exp_pcm.size(), 0);
        $display("pass %0d: comb=%0d pcm_samples=%0d finish_expected=%0d overrun=%0d",
                 idx, v.comb, n_pcm, v.exp_finish, bus.overrun);
        if (v.clr_after) clear_ovr();
    endtask

    initial begin
        bus.read_enable   = 1'b0;
        bus.comb_enable   = 1'b0;
        bus.pcm_ready     = 1'b1;
        bus.clear_overrun = 1'b0;

        //        comb stall_ch len mid_re mid_ce mid_clr finish ovr  clr_after
        vecs[0] = '{1'b0, -1, 0,  0,  0, 0, 25, 1'b0, 1'b0};
        vecs[1] = '{1'b1, -1, 0,  0,  0, 0, 57, 1'b0, 1'b0};
        vecs[2] = '{1'b1,  3, 5,  0,  0, 0, 62, 1'b0, 1'b0};
        vecs[3] = '{1'b0, -1, 0, 10,  0, 0, 25, OVR,  1'b1};
        vecs[4] = '{1'b1, -1, 0,  0, 26, 0, 57, OVR,  1'b0};
        vecs[5] = '{1'b0, -1, 0,  0,  0, 0, 25, OVR,  1'b1};
        vecs[6] = '{1'b0, -1, 0,  3,  0, 3, 25, OVR,  1'b1};

        repeat (2) @(negedge clk);
        check_idle("in_reset");
        resetn = 1'b0;
        @(negedge clk);
        check_idle("after_reset");

        for (int i = 0; i < 7; i++) run_pass(i, vecs[i]);

        // Reset while waiting on the PCM sink, with an overrun already raised.
        @(negedge clk);
        bus.read_enable = 1'b1;
        bus.comb_enable = 1'b1;
        bus.pcm_ready   = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            bus.read_enable = (t == 5);
            bus.comb_enable = 1'b0;
            if (bus.pcm_valid) break;
        end
        bus.read_enable = 1'b0;
        check("reach_wait_out", int'(bus.pcm_valid), 1);
        check("pre_reset_ovr", int'(bus.overrun), int'(OVR));
        #2 resetn = 1'b1;
        #1 check_idle("async_reset");
        $display("reset during wait_out applied");
        @(negedge clk);
        resetn = 1'b0;
        bus.pcm_ready = 1'b1;
        run_pass(7, '{1'b0, -1, 0, 0, 0, 0, 25, 1'b0, 1'b0});

        @(negedge clk);
        check_idle("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cic_seq.md
# cic_seq

Time-multiplexed sequencer for the multichannel CIC decimator datapath. Each `read_enable` pulse from the PDM timing generator starts one pass: integrator updates for all channels and stages, then, on decimation points, comb updates with per-channel PCM output over a valid/ready handshake. It drives the channel/stage index, state-memory address and write strobes of the shared integrator/comb arithmetic, and reports pass completion on `cic_finish`.

## Interface
- `CHANNELS`, 8, microphone channels served per pass
- `STAGES`, 3, CIC order (integrator and comb stages per channel)
- `CHANNELS_WIDTH`, `$clog2(CHANNELS)`, channel index width
- `STAGE_WIDTH`, `$clog2(STAGES)`, stage index width (min 1)
- `ADDR_WIDTH`, `CHANNELS_WIDTH+STAGE_WIDTH`, state-memory address width
- `clk` in 1 system clock
- `resetn` in 1 asynchronous, active-high reset (despite the name)
- `read_enable` in 1 one-cycle pulse; PDM bits valid, start pass
- `comb_enable` in 1 decimation point for the current PDM period
- `pcm_ready` in 1 downstream accepts the current PCM sample
- `clear_overrun` in 1 clears sticky `overrun`
- `channel` out CHANNELS_WIDTH current channel
- `stage` out STAGE_WIDTH current stage
- `mem_addr` out ADDR_WIDTH `{channel, stage}`
- `integ_we` out 1 integrator state write strobe
- `comb_we` out 1 comb state write strobe
- `pcm_valid` out 1 comb output for `pcm_channel` is valid
- `pcm_channel` out CHANNELS_WIDTH channel tag of the PCM sample
- `cic_finish` out 1 one-cycle pulse, pass complete
- `busy` out 1 high in every state except S_IDLE
- `overrun` out 1 sticky request-loss flag

## Operation
- States: S_IDLE, S_INTEG, S_COMB, S_WAIT_OUT, S_DONE.
- S_IDLE: `read_enable` -> S_INTEG, channel=0, stage=0.
- S_INTEG: `integ_we`=1 every cycle. Stage increments and wraps at STAGES-1, then channel increments. After (CHANNELS-1, STAGES-1): go to S_COMB (channel=0, stage=0) if `comb_pending`, else S_DONE.
- `comb_pending` is set by `comb_enable` in S_IDLE or S_INTEG and cleared in S_DONE.
- S_COMB: `comb_we`=1 every cycle. Stage increments. After stage STAGES-1: go to S_WAIT_OUT with stage=0.
- S_WAIT_OUT: `pcm_valid`=1 and `pcm_channel`=channel. Hold until `pcm_ready`. On handshake: if last channel, go to S_DONE; else increment channel and go to S_COMB.
- S_DONE: `cic_finish`=1 for one cycle, then S_IDLE. `channel` and `stage` return to 0.
- Overrun events set `overrun`:
  - `read_enable` outside S_IDLE; the request is dropped.
  - `comb_enable` in S_COMB, S_WAIT_OUT or S_DONE; the request is ignored.
- Simultaneous overrun event and `clear_overrun`: set wins.
- All outputs decode registered state and counters only; there is no input-to-output combinational path.

## Timing
- Reset values: every output 0, state S_IDLE, `comb_pending` 0.
- Reset mid-pass: immediate return to S_IDLE. Pending comb is dropped; `pcm_valid` falls without a handshake.
- `read_enable` at cycle 0: `integ_we` high on cycles 1..C·S.
- No comb: `cic_finish` at cycle C·S+1.
- Comb with `pcm_ready` tied high: S+1 cycles per channel; `cic_finish` at cycle C·S + C·(S+1) + 1. Defaults give 57.
- Each `pcm_ready` stall cycle adds one cycle.
- A new `read_enable` is accepted on the cycle after `cic_finish`.
- `read_enable` and `comb_enable` in the same S_IDLE cycle: both accepted.

## Configuration
- `CIC_SEQ_OVERRUN_EN` defined: overrun detection and sticky `overrun` with `clear_overrun` as specified.
- Undefined: `overrun` is tied 0 and `clear_overrun` is ignored. Dropped and ignored requests are still discarded silently; sequencing is unchanged.

## Structure
- Shared package `cic_pkg`: state encodings S_IDLE..S_DONE (3-bit localparams) and default CHANNELS/STAGES constants.
- One sub-module, `cic_seq_counter`:
  - Nested channel/stage counter with clear, advance, stage-only wrap and last-channel/last-stage flags.
  - Instantiated once.
  - FSM stays in `cic_seq`.

## Test plan
- Reset, then a single `read_enable` without `comb_enable` -> `integ_we` on cycles 1..24, `mem_addr` 0,1,2,4,5,6,…,30, `cic_finish` at cycle 25, no `pcm_valid`.
- `read_enable` plus `comb_enable` together, `pcm_ready`=1 -> 8 `pcm_valid` pulses tagged 0..7, `cic_finish` at cycle 57.
- As above, with `pcm_ready` held low 5 cycles on channel 3 -> `pcm_valid`/`pcm_channel`=3 held stable, `cic_finish` at cycle 62.
- `read_enable` at cycle 10 of a pass -> `overrun`=1 (macro defined), pass unaffected. `clear_overrun` -> 0. With macro undefined, `overrun` stays 0.
- `resetn` asserted during S_WAIT_OUT -> all outputs 0 asynchronously. Next `read_enable` runs a clean integrator-only pass.
- `comb_enable` during S_COMB -> `overrun`=1, no extra comb pass in the following period.
